id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Operand-read and ID/EX pipeline-register stage. Drives the register-file read addresses from the decoded instruction, resolves RAW hazards against in-flight instructions by forwarding or stalling, and registers operands plus control into the ID/EX boundary with a valid/ready handshake toward EX. It sits between the decoder and register file upstream and the execute stage downstream.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- CTRL_W, 16, opaque control bundle width, passed through unchanged
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  REG_AW  source registers
- in_rd  in  REG_AW  destination register
- in_rd_we  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_imm  in  XLEN  decoded immediate
- in_ctrl  in  CTRL_W  control bundle
- rf_rs1, rf_rs2  out  REG_AW  register-file read addresses, equal to in_rs1/in_rs2
- rf_rd1, rf_rd2  in  XLEN  register-file asynchronous read data
- ex_data  in  XLEN  EX-stage ALU result of the instruction held in this stage's output register
- mem_rd  in  REG_AW, mem_we  in  1, mem_data  in  XLEN  EX/MEM writeback candidate
- wb_rd  in  REG_AW, wb_we  in  1, wb_data  in  XLEN  register-file write port, also used as bypass
- flush  in  1  kill the ID and ID/EX contents (branch redirect)
- out_valid  out  1  ID/EX holds a valid instruction
- out_ready  in  1  EX accepts
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands
- out_rd, out_rd_we, out_is_load, out_imm, out_ctrl  out  registered copies

## Operation
- Operand source priority, per operand, with `rsN` != 0:
  1. ID/EX register match (`out_valid && out_rd_we && out_rd==rsN && !out_is_load`): use ex_data.
  2. mem_we && mem_rd==rsN: use mem_data.
  3. wb_we && wb_rd==rsN: use wb_data.
  4. Otherwise use rf_rdN.
- `rsN` == 0 always yields 0, regardless of any match.
- Load-use hazard: `in_valid && out_valid && out_is_load && out_rd_we && out_rd!=0 && (out_rd==in_rs1 || out_rd==in_rs2)`.
- advance = `out_ready || !out_valid`.
- in_ready = `flush || (advance && !hazard)`.
- On a clock edge with advance:
  - If in_valid and in_ready and no flush, load the operands and fields, and set out_valid=1.
  - On a hazard, set out_valid=0 (bubble) and leave the fields don't-care.
- flush=1: out_valid<=0 next edge; the ID-side instruction is consumed and discarded. flush takes priority over stall and over out_ready.
- When !advance, all output registers hold their values.

## Timing
- One cycle of latency from acceptance to out_valid.
- Reset: out_valid=0, and all data and field outputs are 0. in_ready = out_ready || 1 (the output is empty), so it is 1 after reset.
- Load-use costs exactly one bubble. On the next cycle the load sits in MEM and the value is forwarded via mem_data once MEM supplies loaded data on mem_data.
- Holding out_valid with out_ready=0: outputs stable, in_ready=0.
- Asserting rst mid-stall clears out_valid on the same edge.

## Configuration
- ID_FWD_EN defined: forwarding as above.
- ID_FWD_EN undefined: no bypass.
  - Any match against ID/EX, MEM, or WB pending writes (rd != 0) is a hazard and stalls.
  - Operands come only from rf_rdN.
  - Dependent back-to-back instructions incur up to 3 bubbles.

## Structure
- Shared package pipe_pkg: XLEN, REG_AW, CTRL_W, and the id_ex_t struct (operands, rd, rd_we, is_load, imm, ctrl).
- One sub-module, operand_bypass: combinational priority select for one operand, instantiated twice.
- Hazard detection and the pipeline register live in id_ex_stage.

## Test plan
- Reset: assert rst for 2 cycles → out_valid=0, all outputs 0, in_ready=1.
- EX forward: ADD x5 in ID/EX with ex_data=0x11, next instruction rs1=x5 with rf_rd1=0xDEAD → out_rs1_val=0x11 (fwd build).
- Priority: mem_rd=x3/0x22 and wb_rd=x3/0x33 both active, rs2=x3 → 0x22. With rs2=x0 and every rd=0 → 0.
- Load-use: LW x7 in ID/EX, next instruction rs2=x7 → one cycle with in_ready=0 and out_valid=0. The following cycle, mem_data=0x44 is forwarded.
- Backpressure plus flush:
  - out_ready=0 for 3 cycles → outputs stable.
  - flush during the stall → out_valid=0 next edge, in_ready=1.
- Without ID_FWD_EN: an ADD x5 followed by a dependent rs1=x5 → 3 stall cycles, then operand = rf_rd1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the operand-read / ID-EX stage.
// Datapath widths, the ID/EX register layout and a register-match helper.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  // A pending write to rd satisfies a read of rs; x0 never matches.
  function automatic logic reg_hit(input logic we, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return we && (rd == rs) && (rs != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Priority operand select for one source register: ID/EX, then MEM, then WB,
// then register-file data. Reading x0 always yields zero.
module operand_bypass
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              mem_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   rf_data,
  output logic [XLEN-1:0]   val
);

  // Youngest in-flight producer wins
  always_comb begin
    val = rf_data;
    if (rs == {REG_AW{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else if (reg_hit(ex_en, ex_rd, rs)) begin
      val = ex_data;
    end else if (reg_hit(mem_en, mem_rd, rs)) begin
      val = mem_data;
    end else if (reg_hit(wb_en, wb_rd, rs)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Operand read, RAW hazard resolution and ID/EX pipeline register.
// ID_FWD_EN selects bypassing; when undefined every pending-write match stalls.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic [XLEN-1:0]   ex_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

`ifdef ID_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  id_ex_t          stage_r;
  id_ex_t          next_s;
  logic            valid_r;
  logic            advance_s;
  logic            hazard_s;
  logic            ex_pend_s;
  logic            ex_hit_s;
  logic            mem_hit_s;
  logic            wb_hit_s;
  logic            ex_en_s;
  logic            mem_en_s;
  logic            wb_en_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // A load in ID/EX has no data yet, so it is never a bypass source
  assign ex_en_s  = FWD_EN && valid_r && stage_r.rd_we && !stage_r.is_load;
  assign mem_en_s = FWD_EN && mem_we;
  assign wb_en_s  = FWD_EN && wb_we;

  operand_bypass u_byp_rs1 (
    .rs(in_rs1), .ex_en(ex_en_s), .ex_rd(stage_r.rd), .ex_data(ex_data),
    .mem_en(mem_en_s), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(wb_en_s), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_data(rf_rd1), .val(rs1_val_s)
  );

  operand_bypass u_byp_rs2 (
    .rs(in_rs2), .ex_en(ex_en_s), .ex_rd(stage_r.rd), .ex_data(ex_data),
    .mem_en(mem_en_s), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(wb_en_s), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_data(rf_rd2), .val(rs2_val_s)
  );

  // RAW hazard detection against in-flight writers
  always_comb begin
    ex_pend_s = valid_r && stage_r.rd_we && (stage_r.rd != {REG_AW{1'b0}});
    ex_hit_s  = ex_pend_s && ((stage_r.rd == in_rs1) || (stage_r.rd == in_rs2));
    mem_hit_s = reg_hit(mem_we, mem_rd, in_rs1) || reg_hit(mem_we, mem_rd, in_rs2);
    wb_hit_s  = reg_hit(wb_we, wb_rd, in_rs1) || reg_hit(wb_we, wb_rd, in_rs2);
    if (FWD_EN) begin
      hazard_s = in_valid && ex_hit_s && stage_r.is_load;
    end else begin
      hazard_s = in_valid && (ex_hit_s || mem_hit_s || wb_hit_s);
    end
  end

  assign advance_s = out_ready || !valid_r;
  assign in_ready  = flush || (advance_s && !hazard_s);

  // Assemble the next ID/EX contents from the decoded instruction
  always_comb begin
    next_s         = '0;
    next_s.rs1_val = rs1_val_s;
    next_s.rs2_val = rs2_val_s;
    next_s.rd      = in_rd;
    next_s.rd_we   = in_rd_we;
    next_s.is_load = in_is_load;
    next_s.imm     = in_imm;
    next_s.ctrl    = in_ctrl;
  end

  // ID/EX register: reset, then flush, then load/bubble when advancing, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      stage_r <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (advance_s) begin
      if (in_valid && !hazard_s) begin
        valid_r <= 1'b1;
        stage_r <= next_s;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_r;
  assign out_rs1_val = stage_r.rs1_val;
  assign out_rs2_val = stage_r.rs2_val;
  assign out_rd      = stage_r.rd;
  assign out_rd_we   = stage_r.rd_we;
  assign out_is_load = stage_r.is_load;
  assign out_imm     = stage_r.imm;
  assign out_ctrl    = stage_r.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: an architectural register model predicts
// every operand at issue; a small MEM/WB/regfile environment feeds the DUT.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, in_rd_we, in_is_load;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2;
  logic [XLEN-1:0]   in_imm, rf_rd1, rf_rd2, ex_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [REG_AW-1:0] mem_rd, wb_rd, out_rd;
  logic              mem_we, wb_we, flush, out_valid, out_ready, out_rd_we, out_is_load;
  logic [XLEN-1:0]   mem_data, wb_data, out_rs1_val, out_rs2_val, out_imm;

  logic [XLEN-1:0]   rf_arr  [32];
  logic [XLEN-1:0]   arch_rf [32];
  logic [REG_AW-1:0] m_rd, w_rd;
  logic              m_we, w_we;
  logic [XLEN-1:0]   m_data, w_data;
  id_ex_t            exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              fired, acc_ov, rnd_bp;
  int                stalls;

`ifdef ID_FWD_EN
  localparam int DEP_STALLS = 1 - 1;
  localparam int LU_STALLS  = 1;
`else
  localparam int DEP_STALLS = 3;
  localparam int LU_STALLS  = 3;
`endif

  always #5 clk = ~clk;

  assign rf_rd1   = rf_arr[rf_rs1];
  assign rf_rd2   = rf_arr[rf_rs2];
  assign ex_data  = out_is_load ? 32'hBAD0_BAD0 : out_rs1_val + out_imm;
  assign mem_rd   = m_rd;
  assign mem_we   = m_we;
  assign mem_data = m_data;
  assign wb_rd    = w_rd;
  assign wb_we    = w_we;
  assign wb_data  = w_data;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_data(ex_data), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .out_imm(out_imm), .out_ctrl(out_ctrl)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // One clock: sample handshakes, score outputs, update model and environment.
  task automatic tick();
    id_ex_t            e;
    logic              nm_we;
    logic [REG_AW-1:0] nm_rd;
    logic [XLEN-1:0]   nm_data, a, b;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    nm_we = 1'b0; nm_rd = 5'd0; nm_data = 32'd0;
    if (!rst && flush && out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_rs1_val", out_rs1_val, e.rs1_val);
        check_eq("sb_rs2_val", out_rs2_val, e.rs2_val);
        check_eq("sb_fields", {out_rd, out_rd_we, out_is_load, out_imm, out_ctrl},
                 {e.rd, e.rd_we, e.is_load, e.imm, e.ctrl});
      end
      nm_we = out_rd_we; nm_rd = out_rd;
      nm_data = out_is_load ? out_imm : out_rs1_val + out_imm;
    end
    fired  = !rst && in_valid && in_ready && !flush;
    acc_ov = out_valid;
    if (fired) begin
      a = (in_rs1 == 5'd0) ? 32'd0 : arch_rf[in_rs1];
      b = (in_rs2 == 5'd0) ? 32'd0 : arch_rf[in_rs2];
      e = '0;
      e.rs1_val = a; e.rs2_val = b; e.rd = in_rd; e.rd_we = in_rd_we;
      e.is_load = in_is_load; e.imm = in_imm; e.ctrl = in_ctrl;
      exp_q.push_back(e);
      if (in_rd_we && in_rd != 5'd0) arch_rf[in_rd] = in_is_load ? in_imm : a + in_imm;
    end
    @(posedge clk);
    #1;
    if (w_we && w_rd != 5'd0) rf_arr[w_rd] = w_data;
    w_we = m_we; w_rd = m_rd; w_data = m_data;
    m_we = nm_we; m_rd = nm_rd; m_data = nm_data;
  endtask

  task automatic set_instr(input logic [4:0] rs1, rs2, rd, input logic we, ld,
                           input logic [31:0] imm);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = we; in_is_load = ld; in_imm = imm; in_ctrl = 16'($urandom);
  endtask

  task automatic issue(input logic [4:0] rs1, rs2, rd, input logic we, ld,
                       input logic [31:0] imm, output int n_stall);
    set_instr(rs1, rs2, rd, we, ld, imm);
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fired) break;
      n_stall++;
    end
    check_eq("issue_accepted", {63'd0, fired}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_arr[i]  = (i == 0) ? 32'd0 : 32'h0000_1000 + 32'(i);
      arch_rf[i] = rf_arr[i];
    end
    rf_arr[5] = 32'h0000_DEAD; arch_rf[5] = 32'h0000_DEAD;
    m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    w_we = 1'b0; w_rd = 5'd0; w_data = 32'd0;
    rnd_bp = 1'b0; rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rd_we = 1'b0; in_is_load = 1'b0; in_imm = 32'd0; in_ctrl = 16'd0;

    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_operands", {out_rs1_val, out_rs2_val}, 64'd0);
    check_eq("rst_fields", {out_rd, out_rd_we, out_is_load, out_imm, out_ctrl}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // EX forward: ADD x5 <- 0x11 then a reader of x5 whose regfile copy is 0xDEAD
    issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h11, stalls);
    issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0, stalls);
    check_eq("dep_stalls", 64'(stalls), 64'(DEP_STALLS));
    drain(6);

    // x3 written twice (0x33 then 0x22); the reader must see the younger value
    issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h33, stalls);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h22, stalls);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, stalls);
    issue(5'd1, 5'd3, 5'd4, 1'b1, 1'b0, 32'h1, stalls);
    // writes aimed at x0 must never leak into an x0 read
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h55, stalls);
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h66, stalls);
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 32'h7, stalls);
    drain(6);

    // Load-use
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h44, stalls);
    issue(5'd0, 5'd7, 5'd9, 1'b1, 1'b0, 32'h0, stalls);
    check_eq("lu_stalls", 64'(stalls), 64'(LU_STALLS));
    check_eq("lu_bubble", {63'd0, acc_ov}, 64'd0);
    drain(6);

    // Backpressure: held instruction stable, younger one refused
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 32'h99, stalls);
    set_instr(5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_fired", {63'd0, fired}, 64'd0);
      check_eq("bp_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
      check_eq("bp_hold", {out_rs1_val, out_rs2_val}, {exp_q[0].rs1_val, exp_q[0].rs2_val});
      check_eq("bp_hold_ctrl", {out_rd, out_ctrl}, {exp_q[0].rd, exp_q[0].ctrl});
    end
    flush = 1'b1;
    #1;
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
    check_eq("flush_q_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;

    // Random dependent traffic with random backpressure
    rnd_bp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0), $urandom, stalls);
    end
    rnd_bp = 1'b0; out_ready = 1'b1;
    drain(8);
    check_eq("drain_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted while the output is stalled
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 32'h5A, stalls);
    set_instr(5'd1, 5'd1, 5'd12, 1'b0, 1'b0, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_stall_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_stall_imm", 64'(out_imm), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
